cpu_mem_arbiter: RTL and testbench

- Shares the single-port program/data memory between the CPU instruction-fetch path and the load/store path of cpu_logic.
- Sequences each access: select requester, issue it to memory, wait the read latency, return data and a one-cycle ack.
- Sits between cpu_logic and the memory macro. cpu_logic's fetch state holds f_req and the memory state holds d_req until the matching ack arrives.

---
 rtl/cpu_arb_pkg.sv | 18 +
 rtl/arb_rr_pick.sv | 24 ++
 rtl/cpu_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_arb_pkg.sv
// Shared definitions for the CPU memory arbiter: FSM state encoding, owner codes, latency bounds.
package cpu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int LAT_CW     = 2;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner selection between fetch and data requesters.
module arb_rr_pick
    import cpu_arb_pkg::*;
(
    input  logic f_req,
    input  logic d_req,
    input  logic last_owner,
    input  logic fair,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = f_req | d_req;
        grant_owner = OWN_FETCH;
        if (f_req && d_req) begin
            // Round-robin hands the grant to whoever did not win last time.
            grant_owner = fair ? ~last_owner : OWN_DATA;
        end else if (d_req) begin
            grant_owner = OWN_DATA;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Single-port memory arbiter between CPU fetch and load/store paths.
// Optional grant/stall counters are built when CPU_ARB_PERF_EN is defined.
module cpu_mem_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1,
    parameter int FAIR   = 1
) (
    input  logic          CLOCK_50,
    input  logic          KEY,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic [DW-1:0] f_rdata,
    output logic          f_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
`ifdef CPU_ARB_PERF_EN
   ,output logic [15:0]   f_grants,
    output logic [15:0]   d_grants,
    output logic [15:0]   stall_cnt
`endif
);

    localparam logic [LAT_CW-1:0] LAT_INIT = LAT_CW'(RD_LAT - 1);

    arb_state_t        r_state, w_next;
    logic              r_owner, r_last_owner, r_we;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata, r_f_rdata, r_d_rdata;
    logic [LAT_CW-1:0] r_lat_cnt;
    logic              w_grant_valid, w_grant_owner;

    arb_rr_pick u_pick (
        .f_req       (f_req),
        .d_req       (d_req),
        .last_owner  (r_last_owner),
        .fair        (FAIR != 0),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            r_state      <= IDLE;
            r_owner      <= OWN_FETCH;
            r_last_owner <= OWN_DATA;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_f_rdata    <= '0;
            r_d_rdata    <= '0;
            r_lat_cnt    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner      <= w_grant_owner;
                        r_last_owner <= w_grant_owner;
                        if (w_grant_owner == OWN_DATA) begin
                            r_addr  <= d_addr;
                            r_we    <= d_we;
                            r_wdata <= d_wdata;
                        end else begin
                            r_addr <= f_addr;
                            r_we   <= 1'b0;
                        end
                    end
                end
                ISSUE: r_lat_cnt <= LAT_INIT;
                WAIT: begin
                    if (r_lat_cnt == '0) begin
                        if (r_owner == OWN_DATA) r_d_rdata <= mem_rdata;
                        else                     r_f_rdata <= mem_rdata;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_next = ISSUE;
            ISSUE:   w_next = r_we ? RESP : WAIT;
            WAIT:    if (r_lat_cnt == '0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign mem_en    = (r_state == ISSUE);
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign f_ack     = (r_state == RESP) && (r_owner == OWN_FETCH);
    assign d_ack     = (r_state == RESP) && (r_owner == OWN_DATA);
    assign f_rdata   = r_f_rdata;
    assign d_rdata   = r_d_rdata;
    assign busy      = (r_state != IDLE);
    assign owner     = r_owner;

`ifdef CPU_ARB_PERF_EN
    logic [15:0] r_f_grants, r_d_grants, r_stall_cnt;
    logic        w_f_served, w_d_served, w_stall, w_grant_now;

    // A requester counts as served from the cycle it is granted until its ack.
    assign w_grant_now = (r_state == IDLE) && w_grant_valid;
    assign w_f_served  = (r_state == IDLE) ? (w_grant_valid && w_grant_owner == OWN_FETCH)
                                           : (r_owner == OWN_FETCH);
    assign w_d_served  = (r_state == IDLE) ? (w_grant_valid && w_grant_owner == OWN_DATA)
                                           : (r_owner == OWN_DATA);
    assign w_stall     = (f_req && !w_f_served) || (d_req && !w_d_served);

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            r_f_grants  <= '0;
            r_d_grants  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_grant_now && w_grant_owner == OWN_FETCH) r_f_grants <= r_f_grants + 16'd1;
            if (w_grant_now && w_grant_owner == OWN_DATA)  r_d_grants <= r_d_grants + 16'd1;
            if (w_stall && r_stall_cnt != 16'hFFFF)        r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign f_grants  = r_f_grants;
    assign d_grants  = r_d_grants;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed self-checking bench: instance a uses defaults (FAIR=1, RD_LAT=1), instance b uses FAIR=0, RD_LAT=3.
module tb_cpu_mem_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        KEY      = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic        a_f_req, a_d_req, a_d_we;
    logic [31:0] a_f_addr, a_d_addr, a_d_wdata, a_mem_rdata;
    logic [31:0] a_f_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
    logic        a_f_ack, a_d_ack, a_mem_en, a_mem_we, a_busy, a_owner;

    logic        b_f_req, b_d_req, b_d_we;
    logic [31:0] b_f_addr, b_d_addr, b_d_wdata, b_mem_rdata;
    logic [31:0] b_f_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
    logic        b_f_ack, b_d_ack, b_mem_en, b_mem_we, b_busy, b_owner;

`ifdef CPU_ARB_PERF_EN
    logic [15:0] a_f_grants, a_d_grants, a_stall_cnt;
    logic [15:0] b_f_grants, b_d_grants, b_stall_cnt;
`endif

    always #5 CLOCK_50 = ~CLOCK_50;

    cpu_mem_arbiter u_dut_a (
        .CLOCK_50 (CLOCK_50), .KEY (KEY),
        .f_req (a_f_req), .f_addr (a_f_addr), .f_rdata (a_f_rdata), .f_ack (a_f_ack),
        .d_req (a_d_req), .d_we (a_d_we), .d_addr (a_d_addr), .d_wdata (a_d_wdata),
        .d_rdata (a_d_rdata), .d_ack (a_d_ack),
        .mem_en (a_mem_en), .mem_we (a_mem_we), .mem_addr (a_mem_addr),
        .mem_wdata (a_mem_wdata), .mem_rdata (a_mem_rdata),
        .busy (a_busy), .owner (a_owner)
`ifdef CPU_ARB_PERF_EN
       ,.f_grants (a_f_grants), .d_grants (a_d_grants), .stall_cnt (a_stall_cnt)
`endif
    );

    cpu_mem_arbiter #(.RD_LAT(3), .FAIR(0)) u_dut_b (
        .CLOCK_50 (CLOCK_50), .KEY (KEY),
        .f_req (b_f_req), .f_addr (b_f_addr), .f_rdata (b_f_rdata), .f_ack (b_f_ack),
        .d_req (b_d_req), .d_we (b_d_we), .d_addr (b_d_addr), .d_wdata (b_d_wdata),
        .d_rdata (b_d_rdata), .d_ack (b_d_ack),
        .mem_en (b_mem_en), .mem_we (b_mem_we), .mem_addr (b_mem_addr),
        .mem_wdata (b_mem_wdata), .mem_rdata (b_mem_rdata),
        .busy (b_busy), .owner (b_owner)
`ifdef CPU_ARB_PERF_EN
       ,.f_grants (b_f_grants), .d_grants (b_d_grants), .stall_cnt (b_stall_cnt)
`endif
    );

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

`ifdef CPU_ARB_PERF_EN
    // One uncontended access on instance a, bounded wait for the matching ack.
    task automatic a_access(input bit is_d, input bit we);
        bit got;
        got = 1'b0;
        a_d_we = we;
        if (is_d) a_d_req = 1'b1; else a_f_req = 1'b1;
        for (int t = 0; t < 12 && !got; t++) begin
            tick();
            if ((is_d && a_d_ack) || (!is_d && a_f_ack)) got = 1'b1;
        end
        chk("perf_access_ack", got, 1);
        a_f_req = 1'b0;
        a_d_req = 1'b0;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got, exp_own;
        int fa, da;

        a_f_req = 0; a_d_req = 0; a_d_we = 0; a_f_addr = 0; a_d_addr = 0; a_d_wdata = 0; a_mem_rdata = 0;
        b_f_req = 0; b_d_req = 0; b_d_we = 0; b_f_addr = 0; b_d_addr = 0; b_d_wdata = 0; b_mem_rdata = 0;

        // Reset state
        #12;
        chk("rst_busy",   a_busy, 0);
        chk("rst_owner",  a_owner, 0);
        chk("rst_mem_en", a_mem_en, 0);
        chk("rst_f_ack",  a_f_ack, 0);
        chk("rst_addr",   a_mem_addr, 0);
        chk("rst_b_busy", b_busy, 0);
        KEY = 1'b1;
        tick();

        // Fetch alone, RD_LAT=1
        chk("fetch_c0_mem_en", a_mem_en, 0);
        a_f_addr = 32'h4; a_f_req = 1'b1;
        tick();
        chk("fetch_c1_mem_en", a_mem_en, 1);
        chk("fetch_c1_mem_we", a_mem_we, 0);
        chk("fetch_c1_addr",   a_mem_addr, 32'h4);
        chk("fetch_c1_owner",  a_owner, 0);
        chk("fetch_c1_busy",   a_busy, 1);
        tick();
        chk("fetch_c2_mem_en", a_mem_en, 0);
        chk("fetch_c2_f_ack",  a_f_ack, 0);
        a_mem_rdata = 32'hDEADBEEF;
        tick();
        chk("fetch_c3_f_ack",  a_f_ack, 1);
        chk("fetch_c3_rdata",  a_f_rdata, 32'hDEADBEEF);
        chk("fetch_c3_d_ack",  a_d_ack, 0);
        a_f_req = 1'b0; a_mem_rdata = 32'h11111111;
        tick();
        chk("fetch_c4_f_ack",  a_f_ack, 0);
        chk("fetch_c4_busy",   a_busy, 0);
        chk("fetch_c4_rdata",  a_f_rdata, 32'hDEADBEEF);

        // Store alone
        a_d_we = 1'b1; a_d_addr = 32'h100; a_d_wdata = 32'h55; a_d_req = 1'b1;
        tick();
        chk("store_c1_mem_en", a_mem_en, 1);
        chk("store_c1_mem_we", a_mem_we, 1);
        chk("store_c1_addr",   a_mem_addr, 32'h100);
        chk("store_c1_wdata",  a_mem_wdata, 32'h55);
        chk("store_c1_owner",  a_owner, 1);
        tick();
        chk("store_c2_d_ack",  a_d_ack, 1);
        chk("store_c2_f_ack",  a_f_ack, 0);
        a_d_req = 1'b0;
        tick();
        chk("store_c3_d_ack",  a_d_ack, 0);
        chk("store_c3_mem_we", a_mem_we, 0);
        chk("store_c3_addr",   a_mem_addr, 32'h100);
        chk("store_c3_busy",   a_busy, 0);
        chk("store_c3_d_rdata", a_d_rdata, 0);
        chk("store_c3_f_rdata", a_f_rdata, 32'hDEADBEEF);

        // Contention, FAIR=1: last grant was data, so order is F, D, F, D
        a_d_we = 1'b0; a_f_addr = 32'h8; a_d_addr = 32'h200; a_mem_rdata = 32'hC0DE0001;
        a_f_req = 1'b1; a_d_req = 1'b1;
        fa = 0; da = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            exp_own = k[0];
            for (int t = 0; t < 12 && !got; t++) begin
                tick();
                if (a_f_ack || a_d_ack) got = 1'b1;
            end
            chk("cont_got_ack", got, 1);
            chk("cont_f_ack",   a_f_ack, !exp_own);
            chk("cont_d_ack",   a_d_ack, exp_own);
            chk("cont_owner",   a_owner, exp_own);
            chk("cont_addr",    a_mem_addr, exp_own ? 32'h200 : 32'h8);
            fa += int'(a_f_ack);
            da += int'(a_d_ack);
            if (k == 3) begin
                a_f_req = 1'b0; a_d_req = 1'b0;
            end
        end
        chk("cont_f_count", fa, 2);
        chk("cont_d_count", da, 2);
        tick();
        chk("cont_idle_busy", a_busy, 0);
        chk("cont_f_rdata",   a_f_rdata, 32'hC0DE0001);
        chk("cont_d_rdata",   a_d_rdata, 32'hC0DE0001);

        // Contention, FAIR=0, RD_LAT=3 on instance b
        b_d_we = 1'b0; b_f_addr = 32'h20; b_d_addr = 32'h200;
        b_f_req = 1'b1; b_d_req = 1'b1;
        tick();
        chk("fix_c1_mem_en", b_mem_en, 1);
        chk("fix_c1_addr",   b_mem_addr, 32'h200);
        chk("fix_c1_owner",  b_owner, 1);
        tick();
        chk("fix_c2_mem_en", b_mem_en, 0);
        tick();
        tick();
        chk("fix_c4_d_ack",  b_d_ack, 0);
        b_mem_rdata = 32'h0BADF00D;
        tick();
        chk("fix_c5_d_ack",  b_d_ack, 1);
        chk("fix_c5_f_ack",  b_f_ack, 0);
        chk("fix_c5_d_rdata", b_d_rdata, 32'h0BADF00D);
        b_d_req = 1'b0; b_mem_rdata = 32'h0;
        tick();
        chk("fix_c6_mem_en", b_mem_en, 0);
        chk("fix_c6_busy",   b_busy, 0);
        tick();
        chk("fix_c7_mem_en", b_mem_en, 1);
        chk("fix_c7_addr",   b_mem_addr, 32'h20);
        chk("fix_c7_owner",  b_owner, 0);
        tick();
        tick();
        tick();
        chk("fix_c10_f_ack", b_f_ack, 0);
        b_mem_rdata = 32'h600DCAFE;
        tick();
        chk("fix_c11_f_ack",   b_f_ack, 1);
        chk("fix_c11_f_rdata", b_f_rdata, 32'h600DCAFE);
        chk("fix_c11_d_rdata", b_d_rdata, 32'h0BADF00D);
        b_f_req = 1'b0;
        tick();
        chk("fix_c12_busy",  b_busy, 0);

        // Reset in the middle of a WAIT on instance a
        a_f_addr = 32'h30; a_f_req = 1'b1;
        tick();
        tick();
        chk("rstw_pre_busy", a_busy, 1);
        KEY = 1'b0;
        #1;
        chk("rstw_busy",    a_busy, 0);
        chk("rstw_mem_en",  a_mem_en, 0);
        chk("rstw_f_ack",   a_f_ack, 0);
        chk("rstw_addr",    a_mem_addr, 0);
        chk("rstw_wdata",   a_mem_wdata, 0);
        chk("rstw_owner",   a_owner, 0);
        chk("rstw_f_rdata", a_f_rdata, 0);
        chk("rstw_d_rdata", a_d_rdata, 0);
        a_f_req = 1'b0;
        #3;
        KEY = 1'b1;
        tick();
        a_f_addr = 32'h10; a_f_req = 1'b1;
        tick();
        chk("rstw_c1_mem_en", a_mem_en, 1);
        chk("rstw_c1_addr",   a_mem_addr, 32'h10);
        tick();
        tick();
        chk("rstw_c3_f_ack",  a_f_ack, 1);
        a_f_req = 1'b0;
        tick();

`ifdef CPU_ARB_PERF_EN
        // Counters: 3 fetches, 2 stores, first pair contended
        KEY = 1'b0;
        #2;
        KEY = 1'b1;
        tick();
        chk("perf_rst_f", a_f_grants, 0);
        a_d_we = 1'b1; a_f_addr = 32'h4; a_d_addr = 32'h104;
        a_f_req = 1'b1; a_d_req = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 12 && !got; t++) begin
            tick();
            if (a_f_ack) got = 1'b1;
        end
        chk("perf_cont_f_first", got, 1);
        chk("perf_cont_d_idle", a_d_ack, 0);
        a_f_req = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 12 && !got; t++) begin
            tick();
            if (a_d_ack) got = 1'b1;
        end
        chk("perf_cont_d_next", got, 1);
        a_d_req = 1'b0;
        tick();
        a_access(1'b0, 1'b0);
        a_access(1'b1, 1'b1);
        a_access(1'b0, 1'b0);
        chk("perf_f_grants",  a_f_grants, 3);
        chk("perf_d_grants",  a_d_grants, 2);
        chk("perf_stall_min", (a_stall_cnt >= 16'd1), 1);
        chk("perf_b_f_grants", b_f_grants, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
